// File: rtl/flash_cmd_seq.sv
// rtl/flash_cmd_seq.sv - serial NOR read command sequencer in front of the SPI byte master
module flash_cmd_seq #(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [23:0]      req_addr,
    input  logic [LEN_W-1:0] req_len,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             done,
    output logic             error,
    output logic             active,
    output logic             spi_write,
    output logic             spi_read,
    output logic [7:0]       spi_din,
    input  logic [7:0]       spi_dout,
    input  logic             spi_busy
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DRAIN, S_DONE, S_ERR
    } state_t;

    typedef enum logic [1:0] {
        P_ISSUE, P_WAIT_HI, P_WAIT_LO
    } phase_t;

    state_t            state;
    phase_t            phase;
    logic [1:0]        op_q;
    logic [23:0]       addr_q;
    logic [LEN_W-1:0]  remain;
    logic [1:0]        addr_idx;
    logic [CNT_W-1:0]  wait_cnt;

    logic              is_data;
    logic              can_issue;
    logic              timed_out;
    logic [7:0]        tx_byte;

    always_comb begin
        tx_byte = 8'h00;
        case (state)
            S_CMD: begin
                case (op_q)
                    2'd0:    tx_byte = 8'h03;
                    2'd1:    tx_byte = 8'h0B;
                    2'd2:    tx_byte = 8'h05;
                    default: tx_byte = 8'h9F;
                endcase
            end
            S_ADDR: begin
                case (addr_idx)
                    2'd0:    tx_byte = addr_q[23:16];
                    2'd1:    tx_byte = addr_q[15:8];
                    default: tx_byte = addr_q[7:0];
                endcase
            end
            default: tx_byte = 8'h00;
        endcase
    end

    assign is_data   = (state == S_DATA);
    // A data read may only start once the single-entry output register can take its byte.
    assign can_issue = (phase == P_ISSUE) && !spi_busy &&
                       ((state inside {S_CMD, S_ADDR, S_DUMMY}) ||
                        (is_data && (!out_valid || out_ready)));
    assign timed_out = (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            phase     <= P_ISSUE;
            op_q      <= '0;
            addr_q    <= '0;
            remain    <= '0;
            addr_idx  <= '0;
            wait_cnt  <= '0;
            req_ready <= 1'b1;
            out_data  <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            active    <= 1'b0;
            spi_write <= 1'b0;
            spi_read  <= 1'b0;
            spi_din   <= '0;
        end else begin
            spi_write <= 1'b0;
            spi_read  <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            if (out_valid && out_ready)
                out_valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    phase     <= P_ISSUE;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        active    <= 1'b1;
                        op_q      <= req_op;
                        addr_q    <= req_addr;
                        remain    <= req_len;
                        addr_idx  <= '0;
                        state     <= (req_len == '0) ? S_DONE : S_CMD;
                    end
                end

                S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
                    case (phase)
                        P_ISSUE: begin
                            if (can_issue) begin
                                spi_write <= !is_data;
                                spi_read  <= is_data;
                                spi_din   <= tx_byte;
                                wait_cnt  <= '0;
                                phase     <= P_WAIT_HI;
                            end
                        end
                        P_WAIT_HI: begin
                            if (spi_busy) begin
                                wait_cnt <= '0;
                                phase    <= P_WAIT_LO;
                            end else if (timed_out) begin
                                phase <= P_ISSUE;
                                state <= S_ERR;
                            end else begin
                                wait_cnt <= wait_cnt + 1'b1;
                            end
                        end
                        P_WAIT_LO: begin
                            if (!spi_busy) begin
                                phase <= P_ISSUE;
                                case (state)
                                    S_CMD: begin
                                        addr_idx <= '0;
                                        state    <= op_q[1] ? S_DATA : S_ADDR;
                                    end
                                    S_ADDR: begin
                                        if (addr_idx == 2'd2)
                                            state <= (op_q == 2'd1) ? S_DUMMY : S_DATA;
                                        else
                                            addr_idx <= addr_idx + 1'b1;
                                    end
                                    S_DUMMY: state <= S_DATA;
                                    default: begin
                                        out_data  <= spi_dout;
                                        out_valid <= 1'b1;
                                        remain    <= remain - 1'b1;
                                        if (remain == LEN_W'(1))
                                            state <= S_DRAIN;
                                    end
                                endcase
                            end else if (timed_out) begin
                                phase <= P_ISSUE;
                                state <= S_ERR;
                            end else begin
                                wait_cnt <= wait_cnt + 1'b1;
                            end
                        end
                        default: phase <= P_ISSUE;
                    endcase
                end

                S_DRAIN: begin
                    if (!out_valid)
                        state <= S_DONE;
                end

                S_DONE: begin
                    done   <= 1'b1;
                    active <= 1'b0;
                    state  <= S_IDLE;
                end

                S_ERR: begin
                    error  <= 1'b1;
                    active <= 1'b0;
                    state  <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_flash_cmd_seq.sv
// tb/tb_flash_cmd_seq.sv - directed bench for flash_cmd_seq with a small SPI master/flash model
module tb_flash_cmd_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [23:0] req_addr;
    logic [15:0] req_len;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        done;
    logic        error;
    logic        active;
    logic        spi_write;
    logic        spi_read;
    logic [7:0]  spi_din;
    logic [7:0]  spi_dout;
    logic        spi_busy;

    int tests = 0;
    int fails = 0;

    logic [8:0] seq_log[$];
    logic [7:0] out_log[$];
    int         rd_cnt, done_cnt, err_cnt;

    int          model_nb;
    logic [7:0]  model_op;
    logic [23:0] model_addr;
    logic        stuck;

    flash_cmd_seq dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_len(req_len),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .done(done), .error(error), .active(active),
        .spi_write(spi_write), .spi_read(spi_read), .spi_din(spi_din),
        .spi_dout(spi_dout), .spi_busy(spi_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // SPI master + flash: busy rises the cycle after a strobe, falls 3 cycles later with the reply.
    initial begin : spi_model
        int         busy_cnt;
        logic       pend_start;
        logic       strobe;
        logic [7:0] pend, resp;
        int         b;
        logic [7:0] id_bytes[3];
        id_bytes[0] = 8'hC2; id_bytes[1] = 8'h20; id_bytes[2] = 8'h11;
        busy_cnt = 0; pend_start = 1'b0; pend = 8'h00;
        spi_busy = 1'b0; spi_dout = 8'h00;
        forever begin
            @(posedge clk); #1;
            strobe = spi_write || spi_read;
            if (strobe) begin
                tests++;
                if ((spi_write && spi_read) || spi_busy) begin
                    fails++;
                    $display("FAIL spi_strobe: write=%0b read=%0b busy=%0b, required single strobe while idle",
                             spi_write, spi_read, spi_busy);
                end
            end
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    spi_busy = 1'b0;
                    spi_dout = pend;
                end
            end else if (pend_start) begin
                spi_busy   = 1'b1;
                busy_cnt   = 3;
                pend_start = 1'b0;
            end
            if (strobe && !stuck) begin
                b = model_nb;
                model_nb++;
                resp = 8'hFF;
                if (b == 0) model_op = spi_din;
                else if (b <= 3 && (model_op == 8'h03 || model_op == 8'h0B))
                    model_addr = {model_addr[15:0], spi_din};
                case (model_op)
                    8'h03: if (b >= 4) resp = mem(model_addr + 24'(b - 4));
                    8'h0B: if (b == 4) resp = 8'hEE;
                           else if (b >= 5) resp = mem(model_addr + 24'(b - 5));
                    8'h9F: if (b >= 1) resp = id_bytes[(b - 1) % 3];
                    8'h05: if (b >= 1) resp = 8'h02;
                    default: resp = 8'hFF;
                endcase
                pend       = resp;
                pend_start = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (spi_write) seq_log.push_back({1'b0, spi_din});
        if (spi_read) begin
            seq_log.push_back(9'h100);
            rd_cnt++;
        end
        if (out_valid && out_ready) out_log.push_back(out_data);
        if (done)  done_cnt++;
        if (error) err_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_req(input logic [1:0] op, input logic [23:0] a, input logic [15:0] l);
        int n = 0;
        while (!req_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            tests++; fails++;
            $display("FAIL req_ready_wait: req_ready=%0b after %0d cycles, required 1", req_ready, n);
        end
        seq_log.delete(); out_log.delete();
        rd_cnt = 0; done_cnt = 0; err_cnt = 0; model_nb = 0;
        req_op = op; req_addr = a; req_len = l; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_end(input string name, input int budget);
        int n = 0;
        while (done_cnt == 0 && err_cnt == 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (done_cnt != 1 || err_cnt != 0) begin
            fails++;
            $display("FAIL %s_done: done pulses=%0d error pulses=%0d, required 1 and 0", name, done_cnt, err_cnt);
        end
    endtask

    task automatic test_reset();
        tests++;
        if (req_ready !== 1'b1 || out_valid !== 1'b0 || done !== 1'b0 || error !== 1'b0 ||
            active !== 1'b0 || spi_write !== 1'b0 || spi_read !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags: rdy=%0b ov=%0b dn=%0b er=%0b act=%0b wr=%0b rd=%0b, required 1000000",
                     req_ready, out_valid, done, error, active, spi_write, spi_read);
        end
        tests++;
        if (spi_din !== 8'h00 || out_data !== 8'h00) begin
            fails++;
            $display("FAIL reset_data: spi_din=%h out_data=%h, required 00 00", spi_din, out_data);
        end
    endtask

    task automatic test_read();
        logic [8:0] ex_seq[$];
        logic [7:0] ex_out[$];
        logic       act_bad = 1'b0;
        int         n = 0;
        ex_seq = '{9'h003, 9'h001, 9'h023, 9'h045, 9'h100, 9'h100, 9'h100, 9'h100};
        ex_out = '{8'h3C, 8'h3F, 8'h3E, 8'h31};
        out_ready = 1'b1;
        send_req(2'd0, 24'h012345, 16'd4);
        while (!done && n < 300) begin
            if (active !== 1'b1) act_bad = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (act_bad || done !== 1'b1 || active !== 1'b0) begin
            fails++;
            $display("FAIL read_active: dropped=%0b done=%0b active_at_done=%0b, required 0 1 0", act_bad, done, active);
        end
        wait_end("read", 10);
        tests++;
        if (seq_log.size() != ex_seq.size()) begin
            fails++;
            $display("FAIL read_seq_len: got %0d, required %0d", seq_log.size(), ex_seq.size());
        end else foreach (ex_seq[i]) begin
            tests++;
            if (seq_log[i] !== ex_seq[i]) begin
                fails++;
                $display("FAIL read_seq[%0d]: got %h, required %h", i, seq_log[i], ex_seq[i]);
            end
        end
        tests++;
        if (out_log.size() != ex_out.size()) begin
            fails++;
            $display("FAIL read_out_len: got %0d, required %0d", out_log.size(), ex_out.size());
        end else foreach (ex_out[i]) begin
            tests++;
            if (out_log[i] !== ex_out[i]) begin
                fails++;
                $display("FAIL read_out[%0d]: got %h, required %h", i, out_log[i], ex_out[i]);
            end
        end
    endtask

    task automatic test_fast_read();
        logic [8:0] ex_seq[$];
        ex_seq = '{9'h00B, 9'h000, 9'h000, 9'h010, 9'h000, 9'h100, 9'h100};
        send_req(2'd1, 24'h000010, 16'd2);
        wait_end("fast_read", 300);
        tests++;
        if (seq_log.size() != ex_seq.size()) begin
            fails++;
            $display("FAIL fast_seq_len: got %0d, required %0d", seq_log.size(), ex_seq.size());
        end else foreach (ex_seq[i]) begin
            tests++;
            if (seq_log[i] !== ex_seq[i]) begin
                fails++;
                $display("FAIL fast_seq[%0d]: got %h, required %h", i, seq_log[i], ex_seq[i]);
            end
        end
        tests++;
        if (out_log.size() != 2 || out_log[0] !== 8'h4A || out_log[1] !== 8'h4B) begin
            fails++;
            $display("FAIL fast_out: got %0d beats first=%h, required 2 beats 4a 4b",
                     out_log.size(), (out_log.size() > 0) ? out_log[0] : 8'hxx);
        end
    endtask

    task automatic test_rdid();
        send_req(2'd3, 24'hABCDEF, 16'd3);
        wait_end("rdid", 300);
        tests++;
        if (seq_log.size() != 4 || seq_log[0] !== 9'h09F || seq_log[1] !== 9'h100 ||
            seq_log[2] !== 9'h100 || seq_log[3] !== 9'h100) begin
            fails++;
            $display("FAIL rdid_seq: got %0d entries first=%h, required 9f then 3 reads",
                     seq_log.size(), (seq_log.size() > 0) ? seq_log[0] : 9'hxxx);
        end
        tests++;
        if (out_log.size() != 3 || out_log[0] !== 8'hC2 || out_log[1] !== 8'h20 || out_log[2] !== 8'h11) begin
            fails++;
            $display("FAIL rdid_out: got %0d beats first=%h, required c2 20 11",
                     out_log.size(), (out_log.size() > 0) ? out_log[0] : 8'hxx);
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        out_ready = 1'b0;
        send_req(2'd0, 24'h000100, 16'd3);
        while (!out_valid && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (20) @(posedge clk);
        #1;
        tests++;
        if (rd_cnt != 1 || out_valid !== 1'b1 || out_data !== 8'h5B) begin
            fails++;
            $display("FAIL bp_hold: reads=%0d out_valid=%0b out_data=%h, required 1 1 5b", rd_cnt, out_valid, out_data);
        end
        out_ready = 1'b1;
        wait_end("bp", 300);
        tests++;
        if (out_log.size() != 3 || out_log[0] !== 8'h5B || out_log[1] !== 8'h5A || out_log[2] !== 8'h59) begin
            fails++;
            $display("FAIL bp_out: got %0d beats first=%h, required 5b 5a 59",
                     out_log.size(), (out_log.size() > 0) ? out_log[0] : 8'hxx);
        end
    endtask

    task automatic test_len0();
        send_req(2'd0, 24'h000000, 16'd0);
        tests++;
        if (done !== 1'b0 || active !== 1'b1) begin
            fails++;
            $display("FAIL len0_first: done=%0b active=%0b, required 0 1", done, active);
        end
        @(posedge clk); #1;
        tests++;
        if (done !== 1'b1 || active !== 1'b0 || req_ready !== 1'b0) begin
            fails++;
            $display("FAIL len0_done: done=%0b active=%0b req_ready=%0b, required 1 0 0", done, active, req_ready);
        end
        @(posedge clk); #1;
        tests++;
        if (done !== 1'b0 || req_ready !== 1'b1 || seq_log.size() != 0) begin
            fails++;
            $display("FAIL len0_after: done=%0b req_ready=%0b strobes=%0d, required 0 1 0", done, req_ready, seq_log.size());
        end
    endtask

    task automatic test_timeout();
        int n = 1;
        stuck = 1'b1;
        send_req(2'd0, 24'h000000, 16'd1);
        while (!error && n < 1100) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (!error || n < 1020 || n > 1035) begin
            fails++;
            $display("FAIL timeout_err: error=%0b at cycle %0d, required 1 near 1027", error, n);
        end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (req_ready !== 1'b1 || active !== 1'b0 || err_cnt != 1 || done_cnt != 0 ||
            seq_log.size() != 1 || seq_log[0] !== 9'h003) begin
            fails++;
            $display("FAIL timeout_after: rdy=%0b act=%0b err=%0d done=%0d strobes=%0d, required 1 0 1 0 1",
                     req_ready, active, err_cnt, done_cnt, seq_log.size());
        end
        stuck = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        send_req(2'd0, 24'h000000, 16'd8);
        while (rd_cnt < 2 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        tests++;
        if (req_ready !== 1'b1 || out_valid !== 1'b0 || done !== 1'b0 || error !== 1'b0 ||
            active !== 1'b0 || spi_write !== 1'b0 || spi_read !== 1'b0 || spi_din !== 8'h00 || out_data !== 8'h00) begin
            fails++;
            $display("FAIL midrst_outputs: rdy=%0b ov=%0b dn=%0b er=%0b act=%0b wr=%0b rd=%0b din=%h od=%h, required 1 and all 0",
                     req_ready, out_valid, done, error, active, spi_write, spi_read, spi_din, out_data);
        end
        repeat (10) @(posedge clk);
        #1;
        tests++;
        if (done_cnt != 0 || err_cnt != 0) begin
            fails++;
            $display("FAIL midrst_pulses: done=%0d error=%0d, required 0 0", done_cnt, err_cnt);
        end
        send_req(2'd0, 24'h0000FF, 16'd1);
        wait_end("midrst_next", 300);
        tests++;
        if (out_log.size() != 1 || out_log[0] !== 8'hA5 || seq_log.size() != 5 || seq_log[3] !== 9'h0FF) begin
            fails++;
            $display("FAIL midrst_next_data: beats=%0d strobes=%0d first=%h, required 1 5 a5",
                     out_log.size(), seq_log.size(), (out_log.size() > 0) ? out_log[0] : 8'hxx);
        end
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_addr = 24'h0; req_len = 16'd0;
        out_ready = 1'b1; stuck = 1'b0;
        model_nb = 0; model_op = 8'h00; model_addr = 24'h0;
        rd_cnt = 0; done_cnt = 0; err_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        test_reset();
        test_read();
        test_fast_read();
        test_rdid();
        test_backpressure();
        test_len0();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
